// File: rtl/fifo_0r0w_status.sv
// fifo_0r0w_status: zero-latency FIFO with occupancy count, almost-full and
// almost-empty hints, synchronous flush and sticky overflow/underflow flags.
// The head entry is visible combinationally. With BYPASS set, a push into an
// empty queue can be popped in the same cycle.
module fifo_0r0w_status #(
   parameter int DWIDTH       = 32,
   parameter int DEPTH        = 32,
   parameter int AFULL_LEVEL  = DEPTH - 4,
   parameter int AEMPTY_LEVEL = 4,
   parameter int BYPASS       = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   output logic                       o_full,
   input  logic [DWIDTH-1:0]          i_wdata,
   input  logic                       i_pop,
   output logic                       o_empty,
   output logic [DWIDTH-1:0]          o_rdata,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_almost_full,
   output logic                       o_almost_empty,
   output logic                       o_overflow,
   output logic                       o_underflow,
   input  logic                       i_clear_err
);

   localparam int AWIDTH = $clog2(DEPTH);
   localparam int CWIDTH = $clog2(DEPTH + 1);

   localparam logic [AWIDTH-1:0] LAST_IDX  = AWIDTH'(DEPTH - 1);
   localparam logic [CWIDTH-1:0] FULL_CNT  = CWIDTH'(DEPTH);
   localparam logic [CWIDTH-1:0] AFULL_CNT = CWIDTH'(AFULL_LEVEL);
   localparam logic [CWIDTH-1:0] AEMPT_CNT = CWIDTH'(AEMPTY_LEVEL);
   localparam logic              BYP_EN    = (BYPASS != 0);

   // Storage is never reset; only the indices and count define validity.
   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic [AWIDTH-1:0] push_idx_q, push_idx_d;
   logic [AWIDTH-1:0] pop_idx_q,  pop_idx_d;
   logic [CWIDTH-1:0] count_q,    count_d;
   logic              ovf_q,      ovf_d;
   logic              unf_q,      unf_d;

   logic cnt_zero;
   logic cnt_full;
   logic fwd_push;
   logic push_ok;
   logic pop_ok;
   logic fwd_hit;
   logic wr_en;

   // Status decode and acceptance; a pop at full frees room for a push.
   always_comb begin
      cnt_zero = (count_q == '0);
      cnt_full = (count_q == FULL_CNT);
      fwd_push = BYP_EN & i_push;
      o_full   = cnt_full & ~i_pop;
      o_empty  = cnt_zero & ~fwd_push;
      push_ok  = i_push & ~o_full;
      pop_ok   = i_pop & ~o_empty;
      // Forwarded transfer: the word goes straight through, nothing is stored.
      fwd_hit  = push_ok & pop_ok & cnt_zero;
      wr_en    = push_ok & ~fwd_hit & ~i_flush;
   end

   // Head data: forwarded write data when empty and bypassing, else the slot at pop_idx.
   always_comb begin
      if (BYP_EN && cnt_zero && i_push) begin
         o_rdata = i_wdata;
      end else begin
         o_rdata = mem_q[pop_idx_q];
      end
   end

   // Next-state for indices, count and the sticky error flags.
   always_comb begin
      push_idx_d = push_idx_q;
      pop_idx_d  = pop_idx_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      if (i_flush) begin
         push_idx_d = '0;
         pop_idx_d  = '0;
         count_d    = '0;
      end else if (!fwd_hit) begin
         if (push_ok) begin
            push_idx_d = (push_idx_q == LAST_IDX) ? '0 : push_idx_q + AWIDTH'(1);
         end
         if (pop_ok) begin
            pop_idx_d = (pop_idx_q == LAST_IDX) ? '0 : pop_idx_q + AWIDTH'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + CWIDTH'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - CWIDTH'(1);
         end
      end

      // Clear first so that a same-cycle error report takes priority.
      if (i_clear_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (i_push && o_full) begin
         ovf_d = 1'b1;
      end
      if (i_pop && o_empty) begin
         unf_d = 1'b1;
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         push_idx_q <= '0;
         pop_idx_q  <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         push_idx_q <= push_idx_d;
         pop_idx_q  <= pop_idx_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Storage write port; dropped pushes, forwarded pushes and flush cycles leave it untouched.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[push_idx_q] <= i_wdata;
      end
   end

   // Registered-count derived outputs.
   always_comb begin
      o_count        = count_q;
      o_almost_full  = (count_q >= AFULL_CNT);
      o_almost_empty = (count_q <= AEMPT_CNT);
      o_overflow     = ovf_q;
      o_underflow    = unf_q;
   end

`ifndef SYNTHESIS
   a_count_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      32'(count_q) <= DEPTH);
   a_push_idx_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      32'(push_idx_q) < DEPTH);
   a_pop_idx_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      32'(pop_idx_q) < DEPTH);
   a_params : assert property (@(posedge i_clk)
      (DWIDTH >= 1) && (DEPTH >= 2) &&
      (AFULL_LEVEL >= 1) && (AFULL_LEVEL <= DEPTH) &&
      (AEMPTY_LEVEL >= 0) && (AEMPTY_LEVEL <= DEPTH - 1) &&
      (BYPASS == 0 || BYPASS == 1));
`endif

endmodule

// File: doc/fifo_0r0w_status.md
Name: fifo_0r0w_status

Overview:
- Successor to the 0-read/0-write-latency FIFO: same combinational read port and same-cycle push-to-pop forwarding when empty.
- Additions:
  - all DEPTH entries usable, with any integer DEPTH;
  - occupancy count output;
  - almost-full and almost-empty flags;
  - synchronous flush;
  - forwarding selectable at elaboration;
  - sticky overflow/underflow error flags. Illegal push/pop is detected and dropped rather than left undefined.
- Used in front-end and LSU queues that need back-pressure hints and error visibility.

Parameters:
- DWIDTH, 32, data width in bits (>=1)
- DEPTH, 32, number of entries (>=2; need not be a power of 2)
- AFULL_LEVEL, DEPTH-4, o_almost_full asserts when count >= this value (1..DEPTH)
- AEMPTY_LEVEL, 4, o_almost_empty asserts when count <= this value (0..DEPTH-1)
- BYPASS, 1, 1 = forward i_wdata to o_rdata when empty and pushing; 0 = no forwarding
- Derived: AWIDTH = $clog2(DEPTH); CWIDTH = $clog2(DEPTH+1)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush; discards all contents
- i_push  in  1  write request
- o_full  out  1  combinational; push would be illegal this cycle
- i_wdata  in  DWIDTH  write data
- i_pop  in  1  read request
- o_empty  out  1  combinational; pop would be illegal this cycle
- o_rdata  out  DWIDTH  head data, combinational (0-cycle)
- o_count  out  CWIDTH  registered occupancy, 0..DEPTH
- o_almost_full  out  1  count >= AFULL_LEVEL (from registered count)
- o_almost_empty  out  1  count <= AEMPTY_LEVEL (from registered count)
- o_overflow  out  1  sticky: push attempted while o_full
- o_underflow  out  1  sticky: pop attempted while o_empty
- i_clear_err  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset:
  - One clock, i_clk. Reset is asynchronous and active-low (i_rst_n). Assertion immediately clears push_idx, pop_idx, count, o_overflow and o_underflow to 0.
  - Memory is not reset.
  - Output values during and after reset: o_count=0, o_full=0, o_almost_empty=1, o_almost_full=0.
  - o_empty = ~(BYPASS & i_push) during and after reset.
  - Reset mid-operation drops all contents. Deassertion is synchronised externally.
- Full and empty:
  - o_full = (count==DEPTH) & ~i_pop.
  - o_empty = (count==0) & ~(BYPASS & i_push).
- Acceptance:
  - push_ok = i_push & ~o_full.
  - pop_ok = i_pop & ~o_empty.
- Read data:
  - If BYPASS & count==0 & i_push, o_rdata = i_wdata.
  - Otherwise o_rdata = mem[pop_idx]. The value is don't-care when o_empty.
- State update (when i_flush=0):
  - push_ok & ~pop_ok: write mem[push_idx]; push_idx advances; count+1.
  - pop_ok & ~push_ok: pop_idx advances; count-1.
  - Both, count==0 (forwarding case): no memory write, indices and count unchanged.
  - Both, count>0: write, both indices advance, count unchanged. This includes count==DEPTH, where pop frees the slot and the push is accepted.
- Index wrap: DEPTH-1 -> 0 via compare, not modulo. Indices never reach DEPTH.
- Flush:
  - i_flush=1 at a clock edge sets push_idx, pop_idx and count to 0.
  - Pushes and pops in the flush cycle have no effect on state.
  - o_rdata and o_empty in the flush cycle still follow the rules above.
  - Flush does not clear the error flags.
- Errors:
  - o_overflow sets on i_push & o_full; the push is dropped and memory is unchanged.
  - o_underflow sets on i_pop & o_empty; no state change.
  - Both flags are evaluated even when i_flush=1.
  - i_clear_err clears both flags. If set and clear occur in the same cycle, set wins.
- BYPASS=0: a pop at count==0 with push asserted is an underflow. The push is still accepted (count becomes 1).
- Sim-only assertions:
  - count never exceeds DEPTH.
  - indices stay below DEPTH.
  - parameter ranges hold.

Test Plan:
- Config DWIDTH=8, DEPTH=5, AFULL_LEVEL=4, AEMPTY_LEVEL=1, BYPASS=1 unless noted.
- Reset, then push 0x11..0x15 on 5 cycles -> o_count 1..5; o_almost_empty drops once count=2; o_almost_full rises at count=4; o_full=1 at count=5 with i_pop=0.
- At count=5, push 0x66 and pop same cycle -> o_rdata=0x11, push accepted, count stays 5. Then pop 5 times -> 0x12,0x13,0x14,0x15,0x66; pointer wrap 4->0 is exercised.
- Empty, push 0xA5 and pop same cycle -> o_empty=0, o_rdata=0xA5, count stays 0, no error.
- Repeat the previous scenario with BYPASS=0 -> o_empty=1, o_underflow=1, count=1. Next cycle o_rdata=0xA5.
- Full plus push without pop -> o_overflow=1, count stays 5, contents unchanged. Assert i_clear_err -> flag clears. Clear and overflow in the same cycle -> flag stays 1.
- Count=3, assert i_flush with push and pop -> next cycle count=0, o_empty=1, error flags unchanged. Async reset mid-stream at count=2 -> o_count=0 before the next clock edge.
